// File: rtl/gpu_cmd_register_file.sv
// gpu_cmd_register_file: Avalon-MM register file that packages vertex/colour state into one
// rasteriser command per START and hands it off over a valid/ready handshake.
module gpu_cmd_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            sel,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] cmd_v0,
  output logic [DATA_WIDTH-1:0] cmd_v1,
  output logic [DATA_WIDTH-1:0] cmd_v2,
  output logic [DATA_WIDTH-1:0] cmd_color
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] vtx0_q, vtx1_q, vtx2_q, color_q, readdata_d, status;
  logic                  ovf_q, ovf_d, serr_q, serr_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  one_hot, multi, wr, start, clr;
  assign one_hot = sel != '0 && (sel & (sel - 6'd1)) == '0;
  assign multi   = sel != '0 && !one_hot;
  assign wr      = write && one_hot;
  assign start   = wr && sel[4] && writedata[0];
  assign clr     = wr && sel[5];
  assign cmd_valid = state_q == PENDING;
  always_comb begin
    status = '0;
    status[0] = cmd_valid;
    status[1] = ovf_q;
    status[2] = serr_q;
    status[8 +: CNT_WIDTH] = cnt_q;
  end
  // CTRL reads as zero, so it shares the fall-through with invalid selects
  assign readdata_d = !one_hot ? '0 : sel[0] ? vtx0_q : sel[1] ? vtx1_q : sel[2] ? vtx2_q :
                      sel[3] ? color_q : sel[5] ? status : '0;
  // sticky set events take priority over a same-cycle W1C clear
  assign ovf_d  = (start && cmd_valid) || (ovf_q && !(clr && writedata[1]));
  assign serr_d = (multi && (write || read)) || (serr_q && !(clr && writedata[2]));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      {vtx0_q, vtx1_q, vtx2_q, color_q} <= '0;
      {cmd_v0, cmd_v1, cmd_v2, cmd_color} <= '0;
      readdata  <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ovf_q  <= ovf_d;
      serr_q <= serr_d;
      if (read) readdata <= readdata_d;
      if (wr && sel[0]) vtx0_q  <= writedata;
      if (wr && sel[1]) vtx1_q  <= writedata;
      if (wr && sel[2]) vtx2_q  <= writedata;
      if (wr && sel[3]) color_q <= writedata;
      if (state_q == IDLE) begin
        if (start) begin
          {cmd_v0, cmd_v1, cmd_v2, cmd_color} <= {vtx0_q, vtx1_q, vtx2_q, color_q};
          state_q <= PENDING;
        end
      end else if (cmd_ready) begin
        cnt_q   <= cnt_q + CNT_WIDTH'(1);
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_gpu_cmd_register_file.sv
// tb_gpu_cmd_register_file: directed plus randomized register traffic checked against a
// register-map level model of the command register file.
module tb_gpu_cmd_register_file;
  logic        clk = 0, reset_n = 0, write = 0, read = 0, cmd_ready = 0;
  logic [5:0]  sel = '0;
  logic [31:0] writedata = '0, readdata, cmd_v0, cmd_v1, cmd_v2, cmd_color;
  logic        cmd_valid;
  int          checks = 0, errors = 0;

  logic [31:0] m_reg [4];
  logic [31:0] m_cmd [4];
  logic [31:0] m_rd;
  bit          m_pend, m_ovf, m_serr;
  int          m_cnt;

  gpu_cmd_register_file dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_v0(cmd_v0), .cmd_v1(cmd_v1), .cmd_v2(cmd_v2), .cmd_color(cmd_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return 32'(m_cnt) << 8 | 32'(m_serr) << 2 | 32'(m_ovf) << 1 | 32'(m_pend);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin m_reg[k] = '0; m_cmd[k] = '0; end
    m_rd = '0; m_pend = 0; m_ovf = 0; m_serr = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rd"}, readdata, m_rd);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'(m_pend));
    chk({tag, "_v0"}, cmd_v0, m_cmd[0]);
    chk({tag, "_v1"}, cmd_v1, m_cmd[1]);
    chk({tag, "_v2"}, cmd_v2, m_cmd[2]);
    chk({tag, "_col"}, cmd_color, m_cmd[3]);
  endtask

  // One bus cycle: drive, advance the model by the register-map rules, clock, compare.
  task automatic step(input string tag, input logic [5:0] s, input bit w, input bit r,
                      input logic [31:0] d, input bit rdy);
    int n, idx;
    bit one, start, npend;
    sel = s; write = w; read = r; writedata = d; cmd_ready = rdy;
    n = $countones(s);
    idx = 0;
    for (int i = 0; i < 6; i++) if (s[i]) idx = i;
    one = n == 1;
    if (r) m_rd = !one ? 32'h0 : idx < 4 ? m_reg[idx] : idx == 5 ? m_status() : 32'h0;
    start = w && one && idx == 4 && d[0];
    if (w && one && idx == 5) begin
      if (d[1]) m_ovf = 0;
      if (d[2]) m_serr = 0;
    end
    if (start && m_pend) m_ovf = 1;
    if (n > 1 && (w || r)) m_serr = 1;
    npend = m_pend;
    if (m_pend && rdy) begin m_cnt = (m_cnt + 1) % 256; npend = 0; end
    if (start && !m_pend) begin
      for (int k = 0; k < 4; k++) m_cmd[k] = m_reg[k];
      npend = 1;
    end
    m_pend = npend;
    if (w && one && idx < 4) m_reg[idx] = d;
    @(posedge clk); #1;
    sel = '0; write = 0; read = 0; writedata = '0; cmd_ready = 0;
    check_outputs(tag);
  endtask

  task automatic rd(input string tag, input int i);
    step(tag, 6'(1 << i), 0, 1, 32'h0, 0);
  endtask

  task automatic wr(input string tag, input int i, input logic [31:0] d);
    step(tag, 6'(1 << i), 1, 0, d, 0);
  endtask

  initial begin
    logic [5:0]  s;
    logic [31:0] d;
    int          k;
    m_reset();
    #12;
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    chk("rst_rd", readdata, 32'h0);
    reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) rd("t1_read", i);
    chk("t1_rd_const", readdata, 32'h0);

    wr("t2_w", 0, 32'h00100020);
    wr("t2_w", 1, 32'h00300040);
    wr("t2_w", 2, 32'h00500060);
    wr("t2_w", 3, 32'h00FF00FF);
    wr("t2_start", 4, 32'h1);
    chk("t2_valid_const", 32'(cmd_valid), 32'h1);
    chk("t2_v0_const", cmd_v0, 32'h00100020);
    chk("t2_col_const", cmd_color, 32'h00FF00FF);
    rd("t2_stat", 5);
    chk("t2_stat_const", readdata, 32'h00000001);
    rd("t2_ctrl", 4);

    wr("t3_w", 0, 32'hDEADBEEF);
    chk("t3_v0_hold", cmd_v0, 32'h00100020);
    step("t3_accept", 6'b0, 0, 0, 32'h0, 1);
    chk("t3_valid_const", 32'(cmd_valid), 32'h0);
    rd("t3_stat", 5);
    chk("t3_stat_const", readdata, 32'h00000100);
    step("t3_idle_rdy", 6'b0, 0, 0, 32'h0, 1);

    wr("t4_start", 4, 32'h1);
    wr("t4_start2", 4, 32'h1);
    rd("t4_stat", 5);
    chk("t4_stat_low", readdata & 32'hFF, 32'h00000003);
    wr("t4_clr", 5, 32'h2);
    rd("t4_stat2", 5);
    chk("t4_stat2_low", readdata & 32'hFF, 32'h00000001);
    step("t4_rw_same", 6'b000001, 1, 1, 32'hCAFEF00D, 0);
    chk("t4_rw_pre", readdata, 32'hDEADBEEF);
    step("t4_start_rdy", 6'b010000, 1, 0, 32'h1, 1);

    step("t5_multi_w", 6'b000011, 1, 0, 32'h12345678, 0);
    rd("t5_v0", 0);
    rd("t5_v1", 1);
    chk("t5_v1_const", readdata, 32'h00300040);
    rd("t5_stat", 5);
    chk("t5_serr", readdata & 32'h4, 32'h4);
    step("t5_multi_r", 6'b000011, 0, 1, 32'h0, 0);
    chk("t5_multi_rd", readdata, 32'h0);
    wr("t5_clr", 5, 32'h6);
    wr("t5_ctrl0", 4, 32'h0);
    rd("t5_stat2", 5);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k < 6) s = 6'(1 << k);
      else if (k < 8) begin s = 6'b010000; d[0] = 1'($urandom_range(0, 1)); end
      else if (k == 8) s = 6'b000011 << $urandom_range(0, 4);
      else s = 6'b0;
      step("rand", s, bit'($urandom_range(0, 1)), s != 0 && bit'($urandom_range(0, 1)), d,
           bit'($urandom_range(0, 1)));
    end

    if (cmd_valid) step("t6_drain", 6'b0, 0, 0, 32'h0, 1);
    k = m_cnt;
    for (int i = 0; i < 256; i++) begin
      wr("t6_start", 4, 32'h1);
      step("t6_acc", 6'b0, 0, 0, 32'h0, 1);
    end
    rd("t6_stat", 5);
    chk("t6_cnt_wrap", (readdata >> 8) & 32'hFF, 32'(k));
    wr("t6_start", 4, 32'h1);
    #2 reset_n = 0;
    #1 chk("t6_async_valid", 32'(cmd_valid), 32'h0);
    chk("t6_async_v0", cmd_v0, 32'h0);
    m_reset();
    #3 reset_n = 1;
    @(posedge clk); #1;
    rd("t6_stat_rst", 5);
    chk("t6_stat_rst_const", readdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
